rr_arbiter_fsm: RTL and testbench
=================================

// Module: rr_arbiter_fsm
// PURPOSE
//  Round-robin arbiter that shares one FSM-driven resource among N_REQ requesters.
//  Uses a Moore controller: state register, next-state logic and output decode.
//  Grants one requester at a time, bounds each tenure to MAX_HOLD cycles, and inserts a one-cycle dead gap between owners.
//  Sits between the request sources and the shared sequencer.
// PARAMETERS
//  N_REQ    4  number of requesters (2..8)
//  ID_W     2  width of grant_id; must satisfy 2**ID_W >= N_REQ
//  MAX_HOLD 8  maximum consecutive grant cycles per tenure (>=1)
//  CNT_W    4  hold-counter width; must hold MAX_HOLD-1
// PORTS
//  CLK       in   1      rising-edge clock
//  CLR       in   1      synchronous active-high reset
//  req       in   N_REQ  level request, one bit per requester
//  grant     out  N_REQ  one-hot grant; all zero when no owner
//  grant_id  out  ID_W   binary index of owner; valid while busy
//  busy      out  1      high while any grant is asserted
//  timeout   out  1      one-cycle pulse: tenure ended by MAX_HOLD expiry
//  lock      in   1      tenure extension; present only with ARB_LOCK_EN
// BEHAVIOUR
//  Clock and reset:
//   - One clock, CLK.
//   - Reset CLR is synchronous and active-high; it is sampled on the CLK rising edge.
//  Reset values:
//   - state=IDLE, grant=0, grant_id=0, busy=0, timeout=0, hold_cnt=0.
//   - Round-robin pointer last=N_REQ-1, so req[0] has first priority after reset.
//  CLR high takes effect at the next edge from any state, including mid-tenure; the grant drops at that edge.
//  All outputs are decoded from flops only: state, owner, hold_cnt and a timeout flag. No combinational path from req to outputs.
//  States:
//   - IDLE: grant=0. If |req, latch winner into owner; next=GRANT. Otherwise stay.
//   - GRANT: grant=onehot(owner); hold_cnt increments each cycle.
//     - Exit to RELEASE when req[owner]==0, or when hold_cnt==MAX_HOLD-1 (tenure is exactly MAX_HOLD cycles).
//   - RELEASE: grant=0 for exactly one cycle. last<=owner, hold_cnt<=0.
//     - If |req: latch the next winner; next=GRANT. Otherwise next=IDLE.
//  Winner search:
//   - First set bit of req scanning last+1, last+2, ... with modulo-N_REQ wrap-around.
//   - The search excludes nothing; a lone requester regains the grant after the 1-cycle gap.
//  Latency: req rising in IDLE at edge k -> grant high after edge k+1.
//  Tenure:
//   - Owner holds the grant while its req stays high, up to MAX_HOLD cycles.
//   - Other req bits are ignored during GRANT.
//  timeout: high during the RELEASE cycle only when the exit cause was expiry and req[owner] was still 1 at that edge.
//   - Drop and expiry on the same cycle count as a drop: no pulse.
//  Unused req bits at or above N_REQ do not exist; grant_id bits beyond log2(N_REQ) are driven 0.
// CONFIGURATION
//  ARB_LOCK_EN defined:
//   - Adds input lock.
//   - While in GRANT with lock==1, hold_cnt freezes and expiry cannot occur.
//   - Release happens only on req[owner] drop.
//   - When lock falls, counting resumes from the frozen value.
//  ARB_LOCK_EN undefined:
//   - No lock port.
//   - Tenure is always bounded by MAX_HOLD.
// TESTING
//  T1 Reset:
//   - CLR=1 with req=4'b1111 -> grant=0, busy=0, timeout=0.
//   - Release CLR -> grant=4'b0001, grant_id=0, busy=1 one cycle later.
//  T2 Short tenure:
//   - Only req[2] high for 3 cycles, then low -> grant=4'b0100 for 3 cycles.
//   - Then 1 gap cycle, IDLE, no timeout.
//  T3 Saturation (MAX_HOLD=8):
//   - req=4'b1111 held -> grant sequence 0001,0010,0100,1000,0001.
//   - Each grant lasts 8 cycles, separated by a 1-cycle gap; timeout pulses once per gap.
//  T4 Reset mid-tenure:
//   - CLR pulsed on the 4th cycle of grant=4'b0100 -> grant=0 at that edge.
//   - Then req=4'b1010 -> grant=4'b0010 (pointer was reset).
//  T5 Simultaneous drop and expiry:
//   - req[owner] falls on the cycle hold_cnt==MAX_HOLD-1 -> RELEASE, timeout stays 0.
//  T6 ARB_LOCK_EN:
//   - lock=1 with req[1] held for 20 cycles -> grant=4'b0010 for all 20 cycles, no timeout.
//   - Drop lock with req[1] still high -> expiry after the remaining count.

Source files
------------

// File: rtl/rr_arbiter_fsm_if.sv
// Handshake bundle between the request sources and the round-robin arbiter.
// The lock line exists only when ARB_LOCK_EN is defined.
// Signalling: req is a level held by each requester for as long as it wants
// the resource; grant/grant_id/busy report the current owner from registers;
// timeout is a one-cycle pulse; there is no separate ready/ack phase.
interface rr_arbiter_fsm_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             busy;
  logic             timeout;
`ifdef ARB_LOCK_EN
  logic             lock;

  // Requester side drives requests and lock, observes the grant.
  modport master (output req, output lock,
                  input grant, input grant_id, input busy, input timeout);
  // Arbiter side.
  modport slave  (input req, input lock,
                  output grant, output grant_id, output busy, output timeout);
`else
  // Requester side drives requests, observes the grant.
  modport master (output req,
                  input grant, input grant_id, input busy, input timeout);
  // Arbiter side.
  modport slave  (input req,
                  output grant, output grant_id, output busy, output timeout);
`endif
endinterface

// File: rtl/rr_arbiter_fsm.sv
// Round-robin arbiter with a Moore controller (IDLE / GRANT / RELEASE).
// One owner at a time, tenure bounded to MAX_HOLD cycles, and a one-cycle
// dead gap between owners. All outputs come straight from registers.
// Optional feature macro: ARB_LOCK_EN (adds lock, which freezes the hold
// counter and suppresses expiry while asserted).
module rr_arbiter_fsm #(
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic                CLK,
  input  logic                CLR,
  rr_arbiter_fsm_if.slave     arb_if,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic               timeout_q, timeout_d;

  logic [ID_W-1:0]    search_base;
  logic [ID_W-1:0]    winner;
  logic               win_found;
  logic               any_req;
  logic [N_REQ-1:0]   owner_oh;
  logic               owner_req;
  logic               hold_frozen;
  logic               expire;

  assign any_req   = |arb_if.req;
  assign owner_req = |(arb_if.req & owner_oh);

  // Decode the owner index into a one-hot vector.
  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      owner_oh[i] = (owner_q == ID_W'(i));
    end
  end

  // Winner search: first requester after the previous owner, with wrap.
  // In RELEASE the pointer is being updated to the current owner this very
  // cycle, so the search starts from owner_q directly.
  always_comb begin
    winner      = '0;
    win_found   = 1'b0;
    search_base = (state_q == S_RELEASE) ? owner_q : last_q;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!win_found && arb_if.req[(int'(search_base) + i) % N_REQ]) begin
        win_found = 1'b1;
        winner    = ID_W'((int'(search_base) + i) % N_REQ);
      end
    end
  end

  // Lock freezes the hold counter and blocks expiry when the feature exists.
  always_comb begin
`ifdef ARB_LOCK_EN
    hold_frozen = arb_if.lock;
`else
    hold_frozen = 1'b0;
`endif
    expire = !hold_frozen && (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
  end

  // Next-state logic for the controller and its datapath registers.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          owner_d    = winner;
          hold_cnt_d = '0;
          state_d    = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!owner_req || expire) begin
          // A drop on the expiry cycle counts as a drop: no pulse.
          state_d    = S_RELEASE;
          hold_cnt_d = '0;
          timeout_d  = expire && owner_req;
        end else if (!hold_frozen) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        last_d     = owner_q;
        hold_cnt_d = '0;
        if (any_req) begin
          owner_d = winner;
          state_d = S_GRANT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      last_q     <= ID_W'(N_REQ - 1);
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Output decode from registers only.
  assign arb_if.grant    = (state_q == S_GRANT) ? owner_oh : '0;
  assign arb_if.grant_id = owner_q;
  assign arb_if.busy     = (state_q == S_GRANT);
  assign arb_if.timeout  = timeout_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// Directed bench for rr_arbiter_fsm with hand-computed expectations.
module tb_rr_arbiter_fsm;

  localparam int N_REQ    = 4;
  localparam int ID_W     = 2;
  localparam int MAX_HOLD = 8;
  localparam int CNT_W    = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic       CLK;
  logic       CLR;
  logic [1:0] dbg_state;

  int n_cmp;
  int n_err;

  logic [N_REQ-1:0] exp_q[$];

  rr_arbiter_fsm_if #(.N_REQ(N_REQ), .ID_W(ID_W)) arb_if ();

  rr_arbiter_fsm #(
    .N_REQ(N_REQ), .ID_W(ID_W), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK),
    .CLR(CLR),
    .arb_if(arb_if),
    .dbg_state_o(dbg_state)
  );

  // Clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_grant(input string tag, input logic [N_REQ-1:0] g,
                              input logic [ID_W-1:0] id);
    check_val({tag, "_grant"}, 32'(arb_if.grant), 32'(g));
    check_val({tag, "_busy"}, 32'(arb_if.busy), 32'(g != '0));
    if (g != '0) check_val({tag, "_id"}, 32'(arb_if.grant_id), 32'(id));
  endtask

  task automatic expect_gap(input string tag, input logic to);
    check_val({tag, "_grant"}, 32'(arb_if.grant), 32'd0);
    check_val({tag, "_busy"}, 32'(arb_if.busy), 32'd0);
    check_val({tag, "_timeout"}, 32'(arb_if.timeout), 32'(to));
  endtask

  initial begin
    logic [N_REQ-1:0] g;
    n_cmp = 0;
    n_err = 0;
    CLR = 1'b1;
    arb_if.req = '0;
`ifdef ARB_LOCK_EN
    arb_if.lock = 1'b0;
`endif

    // T1: reset with all requests high.
    arb_if.req = 4'b1111;
    cyc();
    cyc();
    expect_gap("t1_rst", 1'b0);
    check_val("t1_state", 32'(dbg_state), 32'(ST_IDLE));
    CLR = 1'b0;
    cyc();
    expect_grant("t1_first", 4'b0001, 2'd0);

    // T3: saturation, five tenures of MAX_HOLD cycles each.
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    while (exp_q.size() > 0) begin
      g = exp_q.pop_front();
      for (int c = 0; c < MAX_HOLD; c++) begin
        expect_grant("t3_hold", g, ID_W'($clog2(int'(g))));
        check_val("t3_to_low", 32'(arb_if.timeout), 32'd0);
        cyc();
      end
      expect_gap("t3_gap", 1'b1);
      check_val("t3_state", 32'(dbg_state), 32'(ST_RELEASE));
      if (exp_q.size() == 0) arb_if.req = '0;
      cyc();
    end
    expect_gap("t3_idle", 1'b0);
    check_val("t3_idle_st", 32'(dbg_state), 32'(ST_IDLE));

    // T2: short tenure of req[2] for 3 cycles.
    arb_if.req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      cyc();
      expect_grant("t2_hold", 4'b0100, 2'd2);
    end
    arb_if.req = '0;
    cyc();
    expect_gap("t2_gap", 1'b0);
    cyc();
    expect_gap("t2_idle", 1'b0);
    check_val("t2_idle_st", 32'(dbg_state), 32'(ST_IDLE));

    // T5: drop on the expiry cycle gives no timeout.
    arb_if.req = 4'b0010;
    cyc();
    for (int c = 0; c < MAX_HOLD; c++) begin
      expect_grant("t5_hold", 4'b0010, 2'd1);
      if (c == MAX_HOLD - 1) arb_if.req = '0;
      cyc();
    end
    expect_gap("t5_gap", 1'b0);
    check_val("t5_state", 32'(dbg_state), 32'(ST_RELEASE));
    cyc();
    check_val("t5_idle_st", 32'(dbg_state), 32'(ST_IDLE));

    // T4: reset on the 4th cycle of a req[2] tenure.
    arb_if.req = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      cyc();
      expect_grant("t4_hold", 4'b0100, 2'd2);
    end
    CLR = 1'b1;
    cyc();
    expect_gap("t4_rst", 1'b0);
    check_val("t4_rst_st", 32'(dbg_state), 32'(ST_IDLE));
    CLR = 1'b0;
    arb_if.req = 4'b1010;
    cyc();
    expect_grant("t4_after", 4'b0010, 2'd1);
    arb_if.req = '0;
    cyc();
    expect_gap("t4_gap", 1'b0);
    cyc();
    check_val("t4_idle_st", 32'(dbg_state), 32'(ST_IDLE));

`ifdef ARB_LOCK_EN
    // T6: lock holds the tenure past MAX_HOLD; expiry resumes after unlock.
    arb_if.lock = 1'b1;
    arb_if.req  = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      cyc();
      expect_grant("t6_lock", 4'b0010, 2'd1);
      check_val("t6_to_low", 32'(arb_if.timeout), 32'd0);
    end
    arb_if.lock = 1'b0;
    for (int c = 1; c < MAX_HOLD; c++) begin
      cyc();
      expect_grant("t6_resume", 4'b0010, 2'd1);
    end
    cyc();
    expect_gap("t6_gap", 1'b1);
    arb_if.req = '0;
    cyc();
    check_val("t6_idle_st", 32'(dbg_state), 32'(ST_IDLE));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
